// File: rtl/fir_mac16.sv
// fir_mac16: time-multiplexed 16-tap FIR, one MAC per cycle; define FIR_SAT_EN to saturate the output instead of wrapping
module fir_mac16 #(
  parameter int WIDTH = 36,
  parameter int COEF_WIDTH = 16,
  parameter int OUT_WIDTH = 24,
  parameter int SHIFT = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_valid,
  input  logic signed [WIDTH-1:0]      f [0:15],
  input  logic                         coef_we,
  input  logic [3:0]                   coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  output logic signed [OUT_WIDTH-1:0]  y,
  output logic                         y_valid,
  output logic                         y_sat,
  output logic                         busy,
  output logic                         overrun
);
  localparam int AW = WIDTH + COEF_WIDTH + 4;
  localparam int PW = WIDTH + COEF_WIDTH;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] idx;
  logic signed [AW-1:0] acc;
  logic signed [WIDTH-1:0] snap [0:15];
  logic signed [COEF_WIDTH-1:0] coef_wr [0:15];
  logic signed [COEF_WIDTH-1:0] coef_act [0:15];
  logic signed [COEF_WIDTH-1:0] coef_nx [0:15];
  logic signed [PW-1:0] prod;
  logic signed [OUT_WIDTH-1:0] y_nx;
  logic capture, sat_nx;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  always_comb begin
    capture = sample_valid && state == IDLE && !busy;
    state_nx = (state == IDLE) ? (capture ? MAC : IDLE) :
               (state == MAC) ? (idx == 4'd15 ? DONE : MAC) : IDLE;
  end
  always_comb begin
    coef_nx = coef_wr;
    if (coef_we) coef_nx[coef_addr] = coef_data;
  end
  always_comb
    prod = PW'(snap[idx]) * PW'(coef_act[idx]);
`ifdef FIR_SAT_EN
  logic signed [AW-SHIFT-1:0] s;
  logic ovf;
  always_comb begin
    s = acc[AW-1:SHIFT];
    ovf = !((&s[AW-SHIFT-1:OUT_WIDTH-1]) || !(|s[AW-SHIFT-1:OUT_WIDTH-1]));
    sat_nx = ovf;
    y_nx = ovf ? (s[AW-SHIFT-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}})
               : s[OUT_WIDTH-1:0];
  end
`else
  always_comb begin
    sat_nx = 1'b0;
    y_nx = acc[SHIFT+OUT_WIDTH-1:SHIFT];
  end
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
      acc <= '0;
      y <= '0;
      y_valid <= 1'b0;
      y_sat <= 1'b0;
      busy <= 1'b0;
      overrun <= 1'b0;
      snap <= '{default: '0};
      coef_wr <= '{default: '0};
      coef_act <= '{default: '0};
    end else begin
      coef_wr <= coef_nx;
      busy <= state_nx != IDLE || state == DONE;
      overrun <= sample_valid && !capture;
      y_valid <= state == DONE;
      if (capture) begin
        snap <= f;
        coef_act <= coef_nx;
        acc <= '0;
        idx <= '0;
      end else if (state == MAC) begin
        acc <= acc + AW'(prod);
        idx <= idx + 4'd1;
      end
      if (state == DONE) begin
        y <= y_nx;
        y_sat <= sat_nx;
      end
    end
  end
endmodule

// File: tb/tb_fir_mac16.sv
// tb_fir_mac16: directed bench for fir_mac16 with a transaction-level model checked every cycle
module tb_fir_mac16;
  logic clk = 0, rst_n = 0, sample_valid = 0, coef_we = 0;
  logic [3:0] coef_addr = 0;
  logic signed [15:0] coef_data = 0;
  logic signed [35:0] f [0:15];
  logic signed [23:0] y;
  logic y_valid, y_sat, busy, overrun;
  int total = 0, bad = 0, yv_cnt = 0, ov_cnt = 0;

  always #5 clk = ~clk;

  fir_mac16 dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .f(f),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .y(y), .y_valid(y_valid), .y_sat(y_sat), .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a sample is accepted when no computation is in flight; its result
  // appears 17 edges later, and the window stays closed one more cycle.
  logic signed [15:0] mcoef [16];
  logic signed [23:0] m_y, pend_y;
  logic m_yv, m_sat, m_busy, m_ov, pend_sat, active, accept;
  logic chk_on = 0;
  int cnt;
  longint m_acc, s;

  always @(posedge clk) begin
    if (!rst_n) begin
      foreach (mcoef[k]) mcoef[k] = 0;
      m_y = 0; m_yv = 0; m_sat = 0; m_busy = 0; m_ov = 0;
      active = 0; cnt = 0; chk_on = 1;
    end else begin
      if (coef_we) mcoef[coef_addr] = coef_data;
      accept = sample_valid && !active;
      m_ov = sample_valid && active;
      m_yv = 0;
      if (active) begin
        cnt++;
        if (cnt == 17) begin m_y = pend_y; m_sat = pend_sat; m_yv = 1; end
        if (cnt == 18) active = 0;
      end
      if (accept) begin
        m_acc = 0;
        for (int k = 0; k < 16; k++) m_acc += longint'(f[k]) * longint'(mcoef[k]);
        s = m_acc >>> 15;
        pend_sat = 0;
`ifdef FIR_SAT_EN
        if (s > 8388607) begin s = 8388607; pend_sat = 1; end
        else if (s < -8388608) begin s = -8388608; pend_sat = 1; end
`endif
        pend_y = s[23:0];
        active = 1;
        cnt = 0;
      end
      m_busy = active;
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("y", y, m_y);
    chk("y_valid", y_valid, m_yv);
    chk("y_sat", y_sat, m_sat);
    chk("busy", busy, m_busy);
    chk("overrun", overrun, m_ov);
    yv_cnt += int'(y_valid);
    ov_cnt += int'(overrun);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wcoef(input int a, input int d);
    coef_we = 1; coef_addr = 4'(a); coef_data = 16'(d);
    tick();
    coef_we = 0;
  endtask

  task automatic pulse();
    sample_valid = 1;
    tick();
    sample_valid = 0;
  endtask

  task automatic set_taps(input longint v);
    for (int k = 0; k < 16; k++) f[k] = 36'(v);
  endtask

  task automatic wait_y(output logic signed [23:0] yy, output int lat, output int nb);
    lat = 1;
    nb = int'(busy);
    while (!y_valid && lat < 40) begin
      tick();
      lat++;
      nb += int'(busy);
    end
    if (!y_valid) chk("y_valid_timeout", 0, 1);
    yy = y;
  endtask

  initial begin
    logic signed [23:0] yy;
    int lat, nb, c0, o0;
    set_taps(0);
    repeat (2) tick();
    rst_n = 1;
    tick();
    chk("rst_y", y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_y_valid", y_valid, 0);

    for (int k = 0; k < 16; k++) wcoef(k, k + 1);
    f[3] = 32768;
    pulse();
    f[3] = -5; f[0] = 999;
    wait_y(yy, lat, nb);
    chk("imp_y", yy, 4);
    chk("imp_latency", lat, 18);
    chk("imp_busy_cycles", nb, 18);
    repeat (2) tick();

    set_taps(0);
    f[0] = 32768;
    pulse();
    repeat (3) tick();
    wcoef(0, 100);
    wait_y(yy, lat, nb);
    chk("shadow_old", yy, 1);
    repeat (2) tick();
    pulse();
    wait_y(yy, lat, nb);
    chk("shadow_new", yy, 100);
    repeat (2) tick();
    coef_we = 1; coef_addr = 0; coef_data = 200; sample_valid = 1;
    tick();
    coef_we = 0; sample_valid = 0;
    wait_y(yy, lat, nb);
    chk("capture_write", yy, 200);
    repeat (2) tick();

    c0 = yv_cnt; o0 = ov_cnt;
    pulse();
    repeat (4) tick();
    f[0] = 65536;
    pulse();
    repeat (30) tick();
    chk("ovr_pulses", ov_cnt - o0, 1);
    chk("ovr_results", yv_cnt - c0, 1);
    chk("ovr_y", y, 200);

    for (int k = 0; k < 16; k++) wcoef(k, 1024);
    set_taps(-2048);
    pulse();
    chk("dc_acc", m_acc, -33554432);
    wait_y(yy, lat, nb);
    chk("dc_y", yy, -1024);
    chk("dc_sat", y_sat, 0);
    repeat (2) tick();

    for (int k = 0; k < 16; k++) wcoef(k, 32767);
    set_taps(longint'(1) << 30);
    pulse();
    wait_y(yy, lat, nb);
`ifdef FIR_SAT_EN
    chk("sat_y", yy, 8388607);
    chk("sat_flag", y_sat, 1);
`else
    chk("wrap_y", yy, -524288);
    chk("wrap_flag", y_sat, 0);
`endif
    repeat (2) tick();

    set_taps(0);
    f[3] = 32768;
    pulse();
    repeat (7) tick();
    rst_n = 0; coef_we = 1; coef_addr = 3; coef_data = 55;
    tick();
    rst_n = 1; coef_we = 0;
    chk("rstmid_y", y, 0);
    chk("rstmid_busy", busy, 0);
    c0 = yv_cnt;
    repeat (25) tick();
    chk("rstmid_no_valid", yv_cnt - c0, 0);
    pulse();
    wait_y(yy, lat, nb);
    chk("rstmid_cleared_coef", yy, 0);
    repeat (2) tick();
    wcoef(3, 9);
    pulse();
    wait_y(yy, lat, nb);
    chk("rstmid_after", yy, 9);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
